hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/md_busy_cnt.sv | 24 ++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the hazard scoreboard: forwarding-select encodings,
// default mult/div latencies and the busy-counter width helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    function automatic int unsigned busy_cnt_w(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: D/E/M stage register info in, stall and forwarding controls out.
interface hazard_scoreboard_if #(
    parameter int RA_W = 5,
    parameter int TN_W = 2
);
    logic [RA_W-1:0] rs_d, rt_d;
    logic            use_rs_d, use_rt_d;
    logic [TN_W-1:0] tuse_rs_d, tuse_rt_d;
    logic [RA_W-1:0] a3_d;
    logic            we_d;
    logic [TN_W-1:0] tnew_d;
    logic            md_start_d, md_div_d, md_use_d;
    logic [RA_W-1:0] rs_e, rt_e, rt_m;
    logic            pc_en, ir_d_en, ir_e_clr;
    logic [1:0]      fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic            fwd_rt_m;
    logic            md_busy;

    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
               a3_d, we_d, tnew_d, md_start_d, md_div_d, md_use_d,
               rs_e, rt_e, rt_m,
        input  pc_en, ir_d_en, ir_e_clr,
               fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
               a3_d, we_d, tnew_d, md_start_d, md_div_d, md_use_d,
               rs_e, rt_e, rt_m,
        output pc_en, ir_d_en, ir_e_clr,
               fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );
endinterface

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy counter: loads a latency on start, counts down to zero and holds.
module md_busy_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] latency,
    output logic             busy
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= latency;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign busy = (count != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard: shadows destination info through E/M/W and derives
// stall and youngest-first forwarding selects, plus mult/div occupancy.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int TN_W     = 2,
    parameter int MULT_LAT = int'(MULT_LAT_DEF),
    parameter int DIV_LAT  = int'(DIV_LAT_DEF)
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned CNT_W = busy_cnt_w(MULT_LAT, DIV_LAT);

    logic [RA_W-1:0] a3_e, a3_m, a3_w;
    logic            we_e, we_m, we_w;
    logic [TN_W-1:0] tnew_e, tnew_m;
    logic            md_start_e, md_div_e;
    logic            md_busy, stall, opnd_hazard;
    fwd_sel_e        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    function automatic logic hazard(input logic rd, input logic [RA_W-1:0] src,
                                    input logic [TN_W-1:0] tuse, input logic [RA_W-1:0] a3,
                                    input logic we, input logic [TN_W-1:0] tnew);
        return rd && (src != '0) && (src == a3) && we && (tnew > tuse);
    endfunction

    function automatic logic hit(input logic [RA_W-1:0] src, input logic [RA_W-1:0] a3,
                                 input logic we, input logic [TN_W-1:0] tnew);
        return (src != '0) && (src == a3) && we && (tnew == '0);
    endfunction

    always_comb begin
        opnd_hazard = hazard(bus.use_rs_d, bus.rs_d, bus.tuse_rs_d, a3_e, we_e, tnew_e)
                    | hazard(bus.use_rs_d, bus.rs_d, bus.tuse_rs_d, a3_m, we_m, tnew_m)
                    | hazard(bus.use_rt_d, bus.rt_d, bus.tuse_rt_d, a3_e, we_e, tnew_e)
                    | hazard(bus.use_rt_d, bus.rt_d, bus.tuse_rt_d, a3_m, we_m, tnew_m);
        stall = opnd_hazard | (bus.md_use_d & (md_busy | md_start_e));
    end

    // W results are always ready, so its Tnew is an implicit zero.
    always_comb begin
        fwd_rs_d = FWD_RF;
        if      (hit(bus.rs_d, a3_e, we_e, tnew_e))       fwd_rs_d = FWD_E;
        else if (hit(bus.rs_d, a3_m, we_m, tnew_m))       fwd_rs_d = FWD_M;
        else if (hit(bus.rs_d, a3_w, we_w, TN_W'(0)))     fwd_rs_d = FWD_W;
        fwd_rt_d = FWD_RF;
        if      (hit(bus.rt_d, a3_e, we_e, tnew_e))       fwd_rt_d = FWD_E;
        else if (hit(bus.rt_d, a3_m, we_m, tnew_m))       fwd_rt_d = FWD_M;
        else if (hit(bus.rt_d, a3_w, we_w, TN_W'(0)))     fwd_rt_d = FWD_W;
        fwd_rs_e = FWD_RF;
        if      (hit(bus.rs_e, a3_m, we_m, tnew_m))       fwd_rs_e = FWD_M;
        else if (hit(bus.rs_e, a3_w, we_w, TN_W'(0)))     fwd_rs_e = FWD_W;
        fwd_rt_e = FWD_RF;
        if      (hit(bus.rt_e, a3_m, we_m, tnew_m))       fwd_rt_e = FWD_M;
        else if (hit(bus.rt_e, a3_w, we_w, TN_W'(0)))     fwd_rt_e = FWD_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a3_e <= '0; we_e <= 1'b0; tnew_e <= '0; md_start_e <= 1'b0; md_div_e <= 1'b0;
            a3_m <= '0; we_m <= 1'b0; tnew_m <= '0;
            a3_w <= '0; we_w <= 1'b0;
        end else begin
            if (stall) begin
                a3_e <= '0; we_e <= 1'b0; tnew_e <= '0; md_start_e <= 1'b0; md_div_e <= 1'b0;
            end else begin
                a3_e       <= bus.a3_d;
                we_e       <= bus.we_d;
                tnew_e     <= bus.tnew_d;
                md_start_e <= bus.md_start_d;
                md_div_e   <= bus.md_div_d;
            end
            a3_m   <= a3_e;
            we_m   <= we_e;
            tnew_m <= (tnew_e != '0) ? tnew_e - TN_W'(1) : '0;
            a3_w   <= a3_m;
            we_w   <= we_m;
        end
    end

    md_busy_cnt #(.CNT_W(CNT_W)) u_md_busy_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (md_start_e),
        .latency (md_div_e ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT)),
        .busy    (md_busy)
    );

    assign bus.pc_en    = !stall;
    assign bus.ir_d_en  = !stall;
    assign bus.ir_e_clr = stall;
    assign bus.fwd_rs_d = fwd_rs_d;
    assign bus.fwd_rt_d = fwd_rt_d;
    assign bus.fwd_rs_e = fwd_rs_e;
    assign bus.fwd_rt_e = fwd_rt_e;
    assign bus.fwd_rt_m = hit(bus.rt_m, a3_w, we_w, TN_W'(0));
    assign bus.md_busy  = md_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic against
// an instruction-level model of the in-flight E/M/W contents.
module tb_hazard_scoreboard;
    localparam int RA_W = 5, TN_W = 2, MULT_LAT = 5, DIV_LAT = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RA_W(RA_W), .TN_W(TN_W)) bus ();
    hazard_scoreboard #(.RA_W(RA_W), .TN_W(TN_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0;

    // In-flight instruction as seen entering E; stage k = 0 (E), 1 (M), 2 (W).
    typedef struct { bit we; int a3; int tnew; bit md; bit div; } instr_t;
    instr_t stg [3];
    instr_t bubble;
    int cyc = 0;
    int busy_end = -1;

    function automatic int eff_tnew(int k);
        if (k == 2) return 0;
        return (stg[k].tnew > k) ? stg[k].tnew - k : 0;
    endfunction

    function automatic int exp_fwd(int src, int first);
        for (int k = first; k < 3; k++)
            if (src != 0 && stg[k].we && stg[k].a3 == src && eff_tnew(k) == 0) return 3 - k;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit s = 0;
        for (int k = 0; k < 2; k++) begin
            if (bus.use_rs_d && bus.rs_d != 0 && stg[k].we && stg[k].a3 == int'(bus.rs_d)
                && eff_tnew(k) > int'(bus.tuse_rs_d)) s = 1;
            if (bus.use_rt_d && bus.rt_d != 0 && stg[k].we && stg[k].a3 == int'(bus.rt_d)
                && eff_tnew(k) > int'(bus.tuse_rt_d)) s = 1;
        end
        if (bus.md_use_d && (cyc <= busy_end || stg[0].md)) s = 1;
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) stg[k] = bubble;
        busy_end = cyc - 1;
    endtask

    task automatic tick();
        bit st;
        instr_t d;
        st = exp_stall();
        d.we = bus.we_d; d.a3 = int'(bus.a3_d); d.tnew = int'(bus.tnew_d);
        d.md = bus.md_start_d; d.div = bus.md_div_d;
        if (stg[0].md) busy_end = cyc + (stg[0].div ? DIV_LAT : MULT_LAT);
        stg[2] = stg[1];
        stg[1] = stg[0];
        stg[0] = st ? bubble : d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_d(int rs, bit use_rs, int tuse_rs, int rt, bit use_rt, int tuse_rt,
                         int a3, bit we, int tnew, bit mds, bit mdd, bit mdu);
        bus.rs_d = RA_W'(rs); bus.use_rs_d = use_rs; bus.tuse_rs_d = TN_W'(tuse_rs);
        bus.rt_d = RA_W'(rt); bus.use_rt_d = use_rt; bus.tuse_rt_d = TN_W'(tuse_rt);
        bus.a3_d = RA_W'(a3); bus.we_d = we; bus.tnew_d = TN_W'(tnew);
        bus.md_start_d = mds; bus.md_div_d = mdd; bus.md_use_d = mdu;
    endtask

    task automatic idle();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.rs_e = '0; bus.rt_e = '0; bus.rt_m = '0;
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        idle();
        #2 rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL reset_pc_en: got %b want 1", bus.pc_en); end
        checks++; if (bus.ir_d_en !== 1'b1) begin errors++; $display("FAIL reset_ir_d_en: got %b want 1", bus.ir_d_en); end
        checks++; if (bus.ir_e_clr !== 1'b0) begin errors++; $display("FAIL reset_ir_e_clr: got %b want 0", bus.ir_e_clr); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", bus.md_busy); end
        checks++; if ({bus.fwd_rs_d, bus.fwd_rt_d, bus.fwd_rs_e, bus.fwd_rt_e, bus.fwd_rt_m} !== 9'd0) begin
            errors++; $display("FAIL reset_fwd: got %b/%b/%b/%b/%b want all 0", bus.fwd_rs_d, bus.fwd_rt_d, bus.fwd_rs_e, bus.fwd_rt_e, bus.fwd_rt_m); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.pc_en !== 1'b1 || bus.md_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got pc_en=%b md_busy=%b want 1/0", bus.pc_en, bus.md_busy); end
    endtask

    task automatic test_load_use();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0);   // lw $8
        tick();
        set_d(8, 1, 1, 0, 0, 0, 9, 1, 1, 0, 0, 0);   // addu $9, $8
        #1;
        checks++; if (bus.pc_en !== 1'b0 || bus.ir_d_en !== 1'b0 || bus.ir_e_clr !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: got pc_en=%b ir_d_en=%b ir_e_clr=%b want 0/0/1", bus.pc_en, bus.ir_d_en, bus.ir_e_clr); end
        tick();
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL load_use_one_stall: got pc_en=%b want 1", bus.pc_en); end
        tick();
        idle(); bus.rs_e = 5'd8; #1;
        checks++; if (bus.fwd_rs_e !== 2'd1) begin errors++; $display("FAIL load_use_fwd_w: got %0d want 1", bus.fwd_rs_e); end
        tick();
        bus.rs_e = 5'd9; #1;
        checks++; if (bus.fwd_rs_e !== 2'd2) begin errors++; $display("FAIL alu_fwd_m_to_e: got %0d want 2", bus.fwd_rs_e); end
    endtask

    task automatic test_branch_fwd();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);   // addu $9
        tick();
        set_d(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // beq $9
        #1;
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL branch_stall: got pc_en=%b want 0", bus.pc_en); end
        tick();
        checks++; if (bus.pc_en !== 1'b1 || bus.fwd_rs_d !== 2'd2) begin
            errors++; $display("FAIL branch_fwd_m: got pc_en=%b fwd_rs_d=%0d want 1/2", bus.pc_en, bus.fwd_rs_d); end
        flush();
        set_d(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);   // write to $0
        tick();
        set_d(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.pc_en !== 1'b1 || bus.fwd_rs_d !== 2'd0) begin
            errors++; $display("FAIL zero_reg: got pc_en=%b fwd_rs_d=%0d want 1/0", bus.pc_en, bus.fwd_rs_d); end
        tick();
        checks++; if (bus.fwd_rt_d !== 2'd0) begin errors++; $display("FAIL zero_reg_m: got %0d want 0", bus.fwd_rt_d); end
    endtask

    task automatic test_priority();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        repeat (3) tick();
        set_d(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        bus.rt_e = 5'd5; #1;
        checks++; if (bus.fwd_rt_d !== 2'd3) begin errors++; $display("FAIL prio_e_wins: got %0d want 3", bus.fwd_rt_d); end
        checks++; if (bus.fwd_rt_e !== 2'd2) begin errors++; $display("FAIL prio_m_over_w: got %0d want 2", bus.fwd_rt_e); end
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL prio_no_stall: got %b want 1", bus.pc_en); end
        flush();
        set_d(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        repeat (2) tick();
        set_d(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.fwd_rt_d !== 2'd2) begin errors++; $display("FAIL prio_drop_e: got %0d want 2", bus.fwd_rt_d); end
    endtask

    task automatic test_store_fwd();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0);   // lw $4
        tick();
        set_d(0, 0, 0, 4, 1, 2, 0, 0, 0, 0, 0, 0);   // sw rt=$4
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL store_no_stall: got %b want 1", bus.pc_en); end
        tick();
        idle();
        tick();
        bus.rt_m = 5'd4; #1;
        checks++; if (bus.fwd_rt_m !== 1'b1) begin errors++; $display("FAIL store_fwd_w: got %b want 1", bus.fwd_rt_m); end
        bus.rt_m = 5'd3; #1;
        checks++; if (bus.fwd_rt_m !== 1'b0) begin errors++; $display("FAIL store_other_reg: got %b want 0", bus.fwd_rt_m); end
    endtask

    task automatic test_div_stall();
        int stall_n, busy_n;
        flush();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);   // div
        tick();
        set_d(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1);   // mflo
        #1;
        stall_n = 0; busy_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.pc_en) break;
            stall_n++;
            if (bus.md_busy) busy_n++;
            tick();
        end
        checks++; if (stall_n != 11) begin errors++; $display("FAIL div_stall_len: got %0d want 11", stall_n); end
        checks++; if (busy_n != 10) begin errors++; $display("FAIL div_busy_len: got %0d want 10", busy_n); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL div_busy_fall: got %b want 0", bus.md_busy); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_mult();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   // mult
        tick();
        set_d(0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);   // addu $6
        tick();
        idle();
        repeat (2) tick();
        set_d(6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checks++; if (bus.md_busy !== 1'b1 || bus.fwd_rs_d !== 2'd1) begin
            errors++; $display("FAIL mult_pre_reset: got md_busy=%b fwd_rs_d=%0d want 1/1", bus.md_busy, bus.fwd_rs_d); end
        rst_n = 1'b0; #2 rst_n = 1'b1;
        model_clear();
        #1;
        checks++; if (bus.md_busy !== 1'b0 || bus.pc_en !== 1'b1 || bus.fwd_rs_d !== 2'd0) begin
            errors++; $display("FAIL mult_abort: got md_busy=%b pc_en=%b fwd_rs_d=%0d want 0/1/0", bus.md_busy, bus.pc_en, bus.fwd_rs_d); end
        tick();
        checks++; if (bus.md_busy !== 1'b0 || bus.pc_en !== 1'b1 ||
                      {bus.fwd_rs_d, bus.fwd_rt_d, bus.fwd_rs_e, bus.fwd_rt_e, bus.fwd_rt_m} !== 9'd0) begin
            errors++; $display("FAIL mult_after_release: got md_busy=%b pc_en=%b fwd_rs_d=%0d want 0/1/0", bus.md_busy, bus.pc_en, bus.fwd_rs_d); end
    endtask

    task automatic test_random();
        bit st;
        flush();
        for (int n = 0; n < 400; n++) begin
            set_d($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            bus.rs_e = RA_W'($urandom_range(0, 3));
            bus.rt_e = RA_W'($urandom_range(0, 3));
            bus.rt_m = RA_W'($urandom_range(0, 3));
            #1;
            st = exp_stall();
            checks++; if (bus.pc_en !== !st || bus.ir_d_en !== !st || bus.ir_e_clr !== st) begin
                errors++; $display("FAIL rnd_stall[%0d]: got pc_en=%b ir_d_en=%b ir_e_clr=%b want stall=%b", n, bus.pc_en, bus.ir_d_en, bus.ir_e_clr, st); end
            checks++; if (bus.fwd_rs_d !== 2'(exp_fwd(int'(bus.rs_d), 0))) begin
                errors++; $display("FAIL rnd_fwd_rs_d[%0d]: got %0d want %0d", n, bus.fwd_rs_d, exp_fwd(int'(bus.rs_d), 0)); end
            checks++; if (bus.fwd_rt_d !== 2'(exp_fwd(int'(bus.rt_d), 0))) begin
                errors++; $display("FAIL rnd_fwd_rt_d[%0d]: got %0d want %0d", n, bus.fwd_rt_d, exp_fwd(int'(bus.rt_d), 0)); end
            checks++; if (bus.fwd_rs_e !== 2'(exp_fwd(int'(bus.rs_e), 1))) begin
                errors++; $display("FAIL rnd_fwd_rs_e[%0d]: got %0d want %0d", n, bus.fwd_rs_e, exp_fwd(int'(bus.rs_e), 1)); end
            checks++; if (bus.fwd_rt_e !== 2'(exp_fwd(int'(bus.rt_e), 1))) begin
                errors++; $display("FAIL rnd_fwd_rt_e[%0d]: got %0d want %0d", n, bus.fwd_rt_e, exp_fwd(int'(bus.rt_e), 1)); end
            checks++; if (bus.fwd_rt_m !== (exp_fwd(int'(bus.rt_m), 2) == 1)) begin
                errors++; $display("FAIL rnd_fwd_rt_m[%0d]: got %b want %0d", n, bus.fwd_rt_m, exp_fwd(int'(bus.rt_m), 2)); end
            checks++; if (bus.md_busy !== (cyc <= busy_end)) begin
                errors++; $display("FAIL rnd_md_busy[%0d]: got %b want %b", n, bus.md_busy, (cyc <= busy_end)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_priority();
        test_store_fwd();
        test_div_stall();
        test_reset_mid_mult();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
